// File: rtl/cv32e40p_fpu_xif_result_buffer.sv
// -----------------------------------------------------------------------------
// cv32e40p_fpu_xif_result_buffer
//
// Result buffer between the fpnew output handshake and the CV-X-IF result
// channel. It decouples FPU pipeline stalls from core result back-pressure,
// drops results whose instruction was killed on the commit interface, and
// forwards the IEEE status flags with each result.
//
// Optional feature macro: CV32E40P_FPU_FFLAGS_ACC_EN
//   defined   : fflags_acc_o is a sticky OR of the fflags of every accepted
//               result; fflags_clr_i clears it
//   undefined : fflags_acc_o is tied to zero, fflags_clr_i is ignored
//
// Parameters:
//   DEPTH    number of entries (power of two, >= 2)
//   FLEN     result data width
//   ID_WIDTH X-IF instruction id width
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   fpu_out_*               FPU result handshake; fpu_tag_i = {id, rd, we}
//   x_commit_*              commit interface (only kills matter here)
//   x_result_*              X-IF result channel towards the core
//   fflags_acc_o/_clr_i     sticky accumulated fflags and its clear
// -----------------------------------------------------------------------------
module cv32e40p_fpu_xif_result_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned FLEN     = 32,
   parameter int unsigned ID_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  fpu_out_valid_i,
   output logic                  fpu_out_ready_o,
   input  logic [FLEN-1:0]       fpu_result_i,
   input  logic [4:0]            fpu_status_i,
   input  logic [ID_WIDTH+5:0]   fpu_tag_i,
   input  logic                  x_commit_valid_i,
   input  logic [ID_WIDTH-1:0]   x_commit_id_i,
   input  logic                  x_commit_kill_i,
   output logic                  x_result_valid_o,
   input  logic                  x_result_ready_i,
   output logic [ID_WIDTH-1:0]   x_result_id_o,
   output logic [FLEN-1:0]       x_result_data_o,
   output logic [4:0]            x_result_rd_o,
   output logic                  x_result_we_o,
   output logic [4:0]            x_result_fflags_o,
   output logic [4:0]            fflags_acc_o,
   input  logic                  fflags_clr_i
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

   typedef struct packed {
      logic [ID_WIDTH-1:0] id;
      logic [4:0]          rd;
      logic                we;
      logic [FLEN-1:0]     data;
      logic [4:0]          fflags;
      logic                killed;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] slot_off_s [DEPTH];

   entry_t              head_s;
   logic                push_s;
   logic                pop_s;
   logic                accept_s;
   logic                kill_s;
   logic [ID_WIDTH-1:0] tag_id_s;

   // Ready depends on the registered count only: a pop in the same cycle
   // never frees a slot for a push while the buffer is full.
   assign fpu_out_ready_o = (count_q != FULL_CNT);
   assign head_s          = mem_q[rd_ptr_q];
   assign x_result_valid_o  = (count_q != ZERO_CNT) && !head_s.killed;
   assign x_result_id_o     = head_s.id;
   assign x_result_data_o   = head_s.data;
   assign x_result_rd_o     = head_s.rd;
   assign x_result_we_o     = head_s.we;
   assign x_result_fflags_o = head_s.fflags;

   assign tag_id_s = fpu_tag_i[ID_WIDTH+5:6];
   assign push_s   = fpu_out_valid_i && fpu_out_ready_o;
   assign accept_s = x_result_valid_o && x_result_ready_i;
   // A killed head is discarded silently, one per cycle.
   assign pop_s    = accept_s || ((count_q != ZERO_CNT) && head_s.killed);
   assign kill_s   = x_commit_valid_i && x_commit_kill_i;

   // Distance of every slot from the read pointer; slot is occupied when
   // this distance is below the count (natural modulo-DEPTH arithmetic).
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         slot_off_s[i] = PTR_W'(i) - rd_ptr_q;
      end
   end

   // Next-state for storage, pointers and count.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      for (int i = 0; i < DEPTH; i++) begin
         if (kill_s && ({1'b0, slot_off_s[i]} < count_q) && (mem_q[i].id == x_commit_id_i)) begin
            mem_d[i].killed = 1'b1;
         end else begin
            mem_d[i].killed = mem_q[i].killed;
         end
      end

      // The push slot is never occupied, so it cannot clash with the kill loop.
      if (push_s) begin
         mem_d[wr_ptr_q].id     = tag_id_s;
         mem_d[wr_ptr_q].rd     = fpu_tag_i[5:1];
         mem_d[wr_ptr_q].we     = fpu_tag_i[0];
         mem_d[wr_ptr_q].data   = fpu_result_i;
         mem_d[wr_ptr_q].fflags = fpu_status_i;
         mem_d[wr_ptr_q].killed = kill_s && (tag_id_s == x_commit_id_i);
         wr_ptr_d               = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage and pointer registers; reset clears contents so outputs read zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= ZERO_CNT;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

`ifdef CV32E40P_FPU_FFLAGS_ACC_EN
   logic [4:0] fflags_acc_q, fflags_acc_d;
   logic [4:0] fflags_add_s;

   // Sticky flags: only results taken on the X-IF handshake contribute;
   // a clear in the same cycle keeps just the newly accepted flags.
   always_comb begin
      fflags_add_s = accept_s ? head_s.fflags : 5'b00000;
      if (fflags_clr_i) begin
         fflags_acc_d = fflags_add_s;
      end else begin
         fflags_acc_d = fflags_acc_q | fflags_add_s;
      end
   end

   // Sticky flags register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fflags_acc_q <= 5'b00000;
      end else begin
         fflags_acc_q <= fflags_acc_d;
      end
   end

   assign fflags_acc_o = fflags_acc_q;
`else
   logic unused_fflags_clr_s;

   assign unused_fflags_clr_s = fflags_clr_i;
   assign fflags_acc_o        = 5'b00000;
`endif

endmodule

// File: tb/tb_cv32e40p_fpu_xif_result_buffer.sv
module tb_cv32e40p_fpu_xif_result_buffer;

   localparam int DEPTH = 4;
   localparam int FLEN  = 32;
   localparam int IDW   = 4;

   logic            clk = 1'b0;
   logic            rst_i;
   logic            fpu_out_valid_i;
   logic            fpu_out_ready_o;
   logic [FLEN-1:0] fpu_result_i;
   logic [4:0]      fpu_status_i;
   logic [IDW+5:0]  fpu_tag_i;
   logic            x_commit_valid_i;
   logic [IDW-1:0]  x_commit_id_i;
   logic            x_commit_kill_i;
   logic            x_result_valid_o;
   logic            x_result_ready_i;
   logic [IDW-1:0]  x_result_id_o;
   logic [FLEN-1:0] x_result_data_o;
   logic [4:0]      x_result_rd_o;
   logic            x_result_we_o;
   logic [4:0]      x_result_fflags_o;
   logic [4:0]      fflags_acc_o;
   logic            fflags_clr_i;

   always #5 clk = ~clk;

   cv32e40p_fpu_xif_result_buffer #(.DEPTH(DEPTH), .FLEN(FLEN), .ID_WIDTH(IDW)) dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .fpu_out_valid_i   (fpu_out_valid_i),
      .fpu_out_ready_o   (fpu_out_ready_o),
      .fpu_result_i      (fpu_result_i),
      .fpu_status_i      (fpu_status_i),
      .fpu_tag_i         (fpu_tag_i),
      .x_commit_valid_i  (x_commit_valid_i),
      .x_commit_id_i     (x_commit_id_i),
      .x_commit_kill_i   (x_commit_kill_i),
      .x_result_valid_o  (x_result_valid_o),
      .x_result_ready_i  (x_result_ready_i),
      .x_result_id_o     (x_result_id_o),
      .x_result_data_o   (x_result_data_o),
      .x_result_rd_o     (x_result_rd_o),
      .x_result_we_o     (x_result_we_o),
      .x_result_fflags_o (x_result_fflags_o),
      .fflags_acc_o      (fflags_acc_o),
      .fflags_clr_i      (fflags_clr_i)
   );

   // Reference model: an ordered queue of pending results.
   typedef struct {
      bit [IDW-1:0]  id;
      bit [4:0]      rd;
      bit            we;
      bit [FLEN-1:0] data;
      bit [4:0]      fl;
      bit            killed;
   } ent_t;

   ent_t     mq[$];
   bit [4:0] macc;
   int       acc_ids[$];
   bit       last_push;
   int       n_cmp = 0;
   int       n_bad = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic compare();
      bit         ev;
      logic [4:0] eacc;
      ev = (mq.size() > 0) && !mq[0].killed;
      chk("ready", fpu_out_ready_o, mq.size() != DEPTH);
      chk("valid", x_result_valid_o, ev);
      if (ev) begin
         chk("id", x_result_id_o, mq[0].id);
         chk("data", x_result_data_o, mq[0].data);
         chk("rd", x_result_rd_o, mq[0].rd);
         chk("we", x_result_we_o, mq[0].we);
         chk("fflags", x_result_fflags_o, mq[0].fl);
      end
`ifdef CV32E40P_FPU_FFLAGS_ACC_EN
      eacc = macc;
`else
      eacc = 5'h00;
`endif
      chk("acc", fflags_acc_o, eacc);
   endtask

   // Advance the model by one clock with the inputs currently driven,
   // step the DUT one clock, then compare on the falling edge.
   task automatic step();
      ent_t     e;
      int       sz;
      bit       ev;
      bit       pop;
      bit [4:0] add;
      sz = mq.size();
      ev = (sz > 0) && !mq[0].killed;
      last_push = 1'b0;
      if (rst_i) begin
         mq.delete();
         macc = 5'h00;
      end else begin
         add = 5'h00;
         if (ev && x_result_ready_i) begin
            acc_ids.push_back(int'(mq[0].id));
            add = mq[0].fl;
         end
         pop = (sz > 0) && (mq[0].killed || x_result_ready_i);
         if (x_commit_valid_i && x_commit_kill_i) begin
            foreach (mq[i]) if (mq[i].id == x_commit_id_i) mq[i].killed = 1'b1;
         end
         if (pop) void'(mq.pop_front());
         if (fpu_out_valid_i && sz != DEPTH) begin
            e.id     = fpu_tag_i[IDW+5:6];
            e.rd     = fpu_tag_i[5:1];
            e.we     = fpu_tag_i[0];
            e.data   = fpu_result_i;
            e.fl     = fpu_status_i;
            e.killed = x_commit_valid_i && x_commit_kill_i && (e.id == x_commit_id_i);
            mq.push_back(e);
            last_push = 1'b1;
         end
         macc = fflags_clr_i ? add : (macc | add);
      end
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic set_push(bit v, bit [IDW-1:0] id, bit [4:0] rd, bit we, bit [31:0] d, bit [4:0] st);
      fpu_out_valid_i = v;
      fpu_tag_i       = {id, rd, we};
      fpu_result_i    = d;
      fpu_status_i    = st;
   endtask

   task automatic drain(int budget);
      for (int t = 0; t < budget && mq.size() > 0; t++) step();
      chk("drain_empty", mq.size(), 0);
   endtask

   logic [4:0] acc_exp;

   initial begin
      rst_i = 1'b1; fpu_out_valid_i = 1'b0; fpu_result_i = '0; fpu_status_i = 5'h00;
      fpu_tag_i = '0; x_commit_valid_i = 1'b0; x_commit_id_i = '0; x_commit_kill_i = 1'b0;
      x_result_ready_i = 1'b0; fflags_clr_i = 1'b0; macc = 5'h00;
      @(negedge clk);
      step(); step();
      rst_i = 1'b0;

      // Idle after reset: everything quiet and zero.
      for (int k = 0; k < 10; k++) begin
         step();
         chk("idle_ready", fpu_out_ready_o, 1'b1);
         chk("idle_valid", x_result_valid_o, 1'b0);
         chk("idle_zero", {x_result_id_o, x_result_data_o, x_result_rd_o, x_result_we_o, x_result_fflags_o, fflags_acc_o}, 64'h0);
      end

      // Single result with the core ready.
      x_result_ready_i = 1'b1;
      set_push(1'b1, 4'd3, 5'd5, 1'b1, 32'h3F80_0000, 5'h01);
      step();
      fpu_out_valid_i = 1'b0;
      chk("single_valid", x_result_valid_o, 1'b1);
      chk("single_id", x_result_id_o, 4'd3);
      chk("single_data", x_result_data_o, 32'h3F80_0000);
      chk("single_rd", x_result_rd_o, 5'd5);
      chk("single_we", x_result_we_o, 1'b1);
      chk("single_fflags", x_result_fflags_o, 5'h01);
      step();
      chk("single_gone", x_result_valid_o, 1'b0);

      // Back-pressure: fill, fifth waits, then drain in order.
      x_result_ready_i = 1'b0;
      acc_ids.delete();
      for (int k = 0; k < 4; k++) begin
         set_push(1'b1, 4'(k), 5'(k + 1), 1'b1, 32'h1000_0000 + 32'(k), 5'h00);
         step();
      end
      chk("full_ready", fpu_out_ready_o, 1'b0);
      set_push(1'b1, 4'd4, 5'd9, 1'b0, 32'h1000_0004, 5'h00);
      step(); step();
      chk("full_head", x_result_id_o, 4'd0);
      chk("full_hold", last_push, 1'b0);
      x_result_ready_i = 1'b1;
      for (int t = 0; t < 20 && acc_ids.size() < 5; t++) begin
         step();
         if (last_push) fpu_out_valid_i = 1'b0;
      end
      chk("order_cnt", acc_ids.size(), 5);
      for (int k = 0; k < 5 && k < acc_ids.size(); k++) chk("order_id", acc_ids[k], k);

      // Kill while held, and kill in the same cycle as a push.
      x_result_ready_i = 1'b0;
      acc_ids.delete();
      set_push(1'b1, 4'd1, 5'd1, 1'b1, 32'hAAAA_0001, 5'h01); step();
      set_push(1'b1, 4'd2, 5'd2, 1'b1, 32'hAAAA_0002, 5'h04); step();
      set_push(1'b1, 4'd3, 5'd3, 1'b1, 32'hAAAA_0003, 5'h10); step();
      fpu_out_valid_i = 1'b0;
      x_commit_valid_i = 1'b1; x_commit_kill_i = 1'b1; x_commit_id_i = 4'd2;
      step();
      set_push(1'b1, 4'd6, 5'd6, 1'b1, 32'hAAAA_0006, 5'h04);
      x_commit_id_i = 4'd6;
      step();
      fpu_out_valid_i = 1'b0; x_commit_valid_i = 1'b0; x_commit_kill_i = 1'b0;
      x_result_ready_i = 1'b1;
      drain(20);
      chk("kill_cnt", acc_ids.size(), 2);
      if (acc_ids.size() == 2) begin
         chk("kill_first", acc_ids[0], 1);
         chk("kill_second", acc_ids[1], 3);
      end
`ifdef CV32E40P_FPU_FFLAGS_ACC_EN
      acc_exp = 5'h11;
`else
      acc_exp = 5'h00;
`endif
      chk("acc_sticky", fflags_acc_o, acc_exp);
      fflags_clr_i = 1'b1; step(); fflags_clr_i = 1'b0;
      chk("acc_clear", fflags_acc_o, 5'h00);

      // Full with simultaneous pop, then steady push+pop streaming.
      x_result_ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         set_push(1'b1, 4'(8 + k), 5'(k), 1'b0, 32'h5000_0000 + 32'(k), 5'h02);
         step();
      end
      x_result_ready_i = 1'b1;
      set_push(1'b1, 4'd12, 5'd12, 1'b1, 32'h5000_0004, 5'h02);
      chk("fullpop_ready", fpu_out_ready_o, 1'b0);
      step();
      chk("fullpop_nopush", last_push, 1'b0);
      for (int k = 0; k < 16; k++) begin
         set_push(1'b1, 4'(k), 5'(k), 1'b1, 32'h6000_0000 + 32'(k), 5'(k));
         step();
         chk("stream_push", last_push, 1'b1);
         chk("stream_cnt", mq.size(), 3);
      end
      fpu_out_valid_i = 1'b0;
      drain(20);

      // Randomized traffic with one reset in the middle.
      for (int c = 0; c < 2000; c++) begin
         fpu_out_valid_i  = ($urandom_range(0, 3) != 0);
         fpu_tag_i        = 10'($urandom);
         fpu_result_i     = $urandom;
         fpu_status_i     = 5'($urandom);
         x_result_ready_i = ($urandom_range(0, 2) != 0);
         x_commit_valid_i = ($urandom_range(0, 3) == 0);
         x_commit_kill_i  = $urandom_range(0, 1);
         x_commit_id_i    = 4'($urandom);
         if (mq.size() > 0 && !mq[0].killed && mq[0].id == x_commit_id_i) x_commit_kill_i = 1'b0;
         fflags_clr_i     = ($urandom_range(0, 15) == 0);
         rst_i            = (c == 1000);
         step();
         if (c == 1000) begin
            chk("midrst_valid", x_result_valid_o, 1'b0);
            chk("midrst_ready", fpu_out_ready_o, 1'b1);
            chk("midrst_data", x_result_data_o, 32'h0);
         end
      end
      rst_i = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cv32e40p_fpu_xif_result_buffer.md
Name: cv32e40p_fpu_xif_result_buffer

Overview:
- Buffers FPU results between the fpnew output handshake and the CV-X-IF result channel in the cv-x-if example testbench core.
- Decouples FPU pipeline stalls from core result back-pressure.
- Drops results whose instruction was killed on the commit interface.
- Forwards IEEE status flags with each result.

Parameters:
DEPTH, 4, number of result entries; power of two, >= 2
FLEN, 32, result data width; matches the FPU package C_FLEN
ID_WIDTH, 4, X-IF instruction id width

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
fpu_out_valid_i  input  1  FPU result valid
fpu_out_ready_o  output  1  buffer can accept a result
fpu_result_i  input  FLEN  FPU result data
fpu_status_i  input  5  fflags {NV,DZ,OF,UF,NX}
fpu_tag_i  input  ID_WIDTH+6  {id, rd[4:0], we}
x_commit_valid_i  input  1  commit transaction valid
x_commit_id_i  input  ID_WIDTH  committed/killed instruction id
x_commit_kill_i  input  1  kill the instruction with x_commit_id_i
x_result_valid_o  output  1  result valid to core
x_result_ready_i  input  1  core accepts result
x_result_id_o  output  ID_WIDTH  result instruction id
x_result_data_o  output  FLEN  result data
x_result_rd_o  output  5  destination register
x_result_we_o  output  1  register write enable
x_result_fflags_o  output  5  per-result fflags
fflags_acc_o  output  5  sticky accumulated fflags
fflags_clr_i  input  1  clear sticky fflags

Behaviour:
- Storage: circular buffer of DEPTH entries {id, rd, we, data, fflags, killed}. Write pointer, read pointer, and count (width $clog2(DEPTH+1)).
- Reset (rst_i=1 at clk edge): pointers=0, count=0, all killed bits=0, fflags_acc_o=0. Output values: x_result_valid_o=0, fpu_out_ready_o=1, data/id/rd/we/fflags outputs=0.
- Push: fpu_out_valid_i && fpu_out_ready_o. Writes the entry at the write pointer; write pointer increments modulo DEPTH.
- fpu_out_ready_o = (count != DEPTH). Combinational from registered count only. No pass-through when full: a same-cycle pop does not raise ready.
- Latency: no fall-through. A pushed entry reaches the head output at the earliest on the next cycle.
- Head: x_result_valid_o = (count != 0) && !killed[rd_ptr]. Output fields come directly from the head entry.
- Pop: either (x_result_valid_o && x_result_ready_i), or (count != 0 && killed[rd_ptr]). A killed head is silently discarded, one per cycle, without asserting valid.
- Valid/data stability: once x_result_valid_o=1, the head and its fields stay stable until accepted. A kill never targets an already-offered head, because the core kills only uncommitted ids and only committed ids produce results.
- Kill: when x_commit_valid_i && x_commit_kill_i, every occupied entry with id == x_commit_id_i sets killed=1. An entry pushed in the same cycle with a matching id is stored with killed=1.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointer wrap-around is natural modulo DEPTH (power of two).
- Reset mid-operation: all entries are discarded immediately, with no further results.
- Commit without kill has no effect on the buffer.

Optional Feature:
CV32E40P_FPU_FFLAGS_ACC_EN
- Defined: fflags_acc_o is a sticky register. Each cycle it ORs in x_result_fflags_o of a result accepted on the X-IF handshake; killed entries do not contribute. fflags_clr_i=1 clears it to 0. Clear and accumulate in the same cycle: the result is the new flags only.
- Undefined: fflags_acc_o tied to 0 and fflags_clr_i ignored.

Test Plan:
- Reset then idle: fpu_out_ready_o=1, x_result_valid_o=0, all outputs 0 for 10 cycles.
- Push id=3, rd=5, we=1, data=0x3F800000, status=0x01 with x_result_ready_i=1: valid asserts the cycle after the push, fields match, then valid=0.
- Hold x_result_ready_i=0 and push 5 results (ids 0..4): ready drops after the 4th push and the 5th waits. Head id=0 stays stable. Release ready: ids 0,1,2,3,4 emerge in order with no loss.
- Push ids 1,2,3, then kill id=2 while held: outputs ids 1,3 only, and the killed slot costs one silent cycle. Kill id=6 in the same cycle as pushing id=6: never output.
- Full buffer with a simultaneous pop: no push accepted that cycle. Continuous push+pop streaming for 16 results across pointer wrap: order preserved, count stays constant.
- With CV32E40P_FPU_FFLAGS_ACC_EN: accept status 0x01 then 0x10 → fflags_acc_o=0x11. A killed entry with 0x04 leaves it 0x11. fflags_clr_i pulse → 0x00. Without the macro, fflags_acc_o=0 throughout.
